// File: rtl/stage_ex_pkg.sv
// Shared operator/category codes, control constants and the multiplier FSM encoding
// used by the execute stage and its iterative multiplier.
package stage_ex_pkg;

    localparam logic [7:0] OPERATOR_NOP   = 8'h00;
    localparam logic [7:0] OPERATOR_AND   = 8'h24;
    localparam logic [7:0] OPERATOR_OR    = 8'h25;
    localparam logic [7:0] OPERATOR_XOR   = 8'h26;
    localparam logic [7:0] OPERATOR_NOR   = 8'h27;
    localparam logic [7:0] OPERATOR_SLL   = 8'h7c;
    localparam logic [7:0] OPERATOR_SRL   = 8'h02;
    localparam logic [7:0] OPERATOR_SRA   = 8'h03;
    localparam logic [7:0] OPERATOR_MULTU = 8'h19;
    localparam logic [7:0] OPERATOR_MFHI  = 8'h10;
    localparam logic [7:0] OPERATOR_MFLO  = 8'h12;

    localparam logic [2:0] CATEGORY_NOP   = 3'd0;
    localparam logic [2:0] CATEGORY_LOGIC = 3'd1;
    localparam logic [2:0] CATEGORY_SHIFT = 3'd2;
    localparam logic [2:0] CATEGORY_MOVE  = 3'd3;
    localparam logic [2:0] CATEGORY_MULT  = 3'd4;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Reset is active-low throughout this pipeline.
    localparam logic RESET_ENABLE = 1'b0;

    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_BUSY = 2'd1,
        STATE_DONE = 2'd2
    } multiplier_state_t;

endpackage

// File: rtl/stage_ex_multiplier.sv
// 32-cycle shift-and-add unsigned multiplier that owns the architectural HI/LO pair.
// A start seen in IDLE launches one multiply; DONE always returns to IDLE.
module multiplier_iterative
    import stage_ex_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    multiplier_state_t state;
    logic [63:0] multiplicand;
    logic [63:0] accumulator;
    logic [63:0] accumulator_next;
    logic [31:0] multiplier;
    logic [4:0]  count;

    always_comb begin
        accumulator_next = accumulator;
        if (multiplier[0]) begin
            accumulator_next = accumulator + multiplicand;
        end
    end

    // The final step writes HI/LO from the next accumulator value so no extra cycle is needed.
    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            state        <= STATE_IDLE;
            multiplicand <= '0;
            multiplier   <= '0;
            accumulator  <= '0;
            count        <= '0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (start) begin
                        multiplicand <= {32'd0, a};
                        multiplier   <= b;
                        accumulator  <= '0;
                        count        <= '0;
                        state        <= STATE_BUSY;
                    end
                end
                STATE_BUSY: begin
                    accumulator  <= accumulator_next;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    count        <= count + 5'd1;
                    if (count == 5'd31) begin
                        hi    <= accumulator_next[63:32];
                        lo    <= accumulator_next[31:0];
                        state <= STATE_DONE;
                    end
                end
                STATE_DONE: begin
                    state <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == STATE_BUSY);
    assign done = (state == STATE_DONE);

endmodule

// File: rtl/stage_ex.sv
// MIPS execute stage: logic/shift/move ALU, forwarding bus to decode, EX/MEM register,
// and the stall request driven by the iterative MULTU unit.
module stage_ex
    import stage_ex_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  operator,
    input  logic [2:0]  category,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        register_write_enable,
    input  logic [4:0]  register_write_address,
    output logic        ex_register_write_enable,
    output logic [4:0]  ex_register_write_address,
    output logic [31:0] ex_register_write_data,
    output logic        mem_register_write_enable,
    output logic [4:0]  mem_register_write_address,
    output logic [31:0] mem_register_write_data,
    output logic        stall_request,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic        multiply_start;
    logic        multiply_busy;
    logic        multiply_done;
    logic [31:0] result;
    logic        result_valid;
    logic [4:0]  shift_amount;

    assign multiply_start = (operator == OPERATOR_MULTU);
    assign shift_amount   = operand_a[4:0];

    multiplier_iterative multiplier_unit (
        .clock (clock),
        .reset (reset),
        .start (multiply_start),
        .a     (operand_a),
        .b     (operand_b),
        .busy  (multiply_busy),
        .done  (multiply_done),
        .hi    (hi),
        .lo    (lo)
    );

    // Anything outside the recognised category/operator pairs yields a zero, non-writing result.
    always_comb begin
        result       = '0;
        result_valid = 1'b0;
        case (category)
            CATEGORY_LOGIC: begin
                case (operator)
                    OPERATOR_AND: begin result = operand_a & operand_b;    result_valid = 1'b1; end
                    OPERATOR_OR:  begin result = operand_a | operand_b;    result_valid = 1'b1; end
                    OPERATOR_XOR: begin result = operand_a ^ operand_b;    result_valid = 1'b1; end
                    OPERATOR_NOR: begin result = ~(operand_a | operand_b); result_valid = 1'b1; end
                    default: ;
                endcase
            end
            CATEGORY_SHIFT: begin
                case (operator)
                    OPERATOR_SLL: begin result = operand_b << shift_amount; result_valid = 1'b1; end
                    OPERATOR_SRL: begin result = operand_b >> shift_amount; result_valid = 1'b1; end
                    OPERATOR_SRA: begin
                        result       = $unsigned($signed(operand_b) >>> shift_amount);
                        result_valid = 1'b1;
                    end
                    default: ;
                endcase
            end
            CATEGORY_MOVE: begin
                case (operator)
                    OPERATOR_MFHI: begin result = hi; result_valid = 1'b1; end
                    OPERATOR_MFLO: begin result = lo; result_valid = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // A MULTU only requests a stall when it can actually start, i.e. the unit is idle.
    assign stall_request = (reset != RESET_ENABLE) &&
                           (multiply_busy || (multiply_start && !multiply_busy && !multiply_done));

    assign ex_register_write_enable  = (register_write_enable == WRITE_ENABLE) && result_valid && !stall_request;
    assign ex_register_write_address = register_write_address;
    assign ex_register_write_data    = result;

    always_ff @(posedge clock) begin
        if (reset == RESET_ENABLE) begin
            mem_register_write_enable  <= WRITE_DISABLE;
            mem_register_write_address <= '0;
            mem_register_write_data    <= '0;
        end else if (stall_request) begin
            mem_register_write_enable  <= WRITE_DISABLE;
            mem_register_write_address <= '0;
            mem_register_write_data    <= '0;
        end else begin
            mem_register_write_enable  <= ex_register_write_enable;
            mem_register_write_address <= ex_register_write_address;
            mem_register_write_data    <= ex_register_write_data;
        end
    end

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed cases plus random instructions compared
// against an arithmetic reference model of the execute stage and HI/LO.
module tb_stage_ex;
    import stage_ex_pkg::*;

    logic        clock;
    logic        reset;
    logic [7:0]  operator;
    logic [2:0]  category;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        register_write_enable;
    logic [4:0]  register_write_address;
    logic        ex_register_write_enable;
    logic [4:0]  ex_register_write_address;
    logic [31:0] ex_register_write_data;
    logic        mem_register_write_enable;
    logic [4:0]  mem_register_write_address;
    logic [31:0] mem_register_write_data;
    logic        stall_request;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    stage_ex dut (
        .clock                      (clock),
        .reset                      (reset),
        .operator                   (operator),
        .category                   (category),
        .operand_a                  (operand_a),
        .operand_b                  (operand_b),
        .register_write_enable      (register_write_enable),
        .register_write_address     (register_write_address),
        .ex_register_write_enable   (ex_register_write_enable),
        .ex_register_write_address  (ex_register_write_address),
        .ex_register_write_data     (ex_register_write_data),
        .mem_register_write_enable  (mem_register_write_enable),
        .mem_register_write_address (mem_register_write_address),
        .mem_register_write_data    (mem_register_write_data),
        .stall_request              (stall_request),
        .hi                         (hi),
        .lo                         (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Returns {valid, data}; shifts expressed as multiply/divide on wide values.
    function automatic logic [32:0] model_result(input logic [7:0] op, input logic [2:0] cat,
                                                 input logic [31:0] a, input logic [31:0] b);
        logic [63:0] scale;
        logic [63:0] wide;
        scale = 64'd1 << a[4:0];
        if (cat == CATEGORY_LOGIC && op == OPERATOR_AND) return {1'b1, a & b};
        if (cat == CATEGORY_LOGIC && op == OPERATOR_OR)  return {1'b1, a | b};
        if (cat == CATEGORY_LOGIC && op == OPERATOR_XOR) return {1'b1, a ^ b};
        if (cat == CATEGORY_LOGIC && op == OPERATOR_NOR) return {1'b1, ~(a | b)};
        if (cat == CATEGORY_SHIFT && op == OPERATOR_SLL) begin
            wide = {32'd0, b} * scale;
            return {1'b1, wide[31:0]};
        end
        if (cat == CATEGORY_SHIFT && op == OPERATOR_SRL) begin
            wide = {32'd0, b} / scale;
            return {1'b1, wide[31:0]};
        end
        if (cat == CATEGORY_SHIFT && op == OPERATOR_SRA) begin
            wide = b[31] ? ~(~{32'hFFFF_FFFF, b} / scale) : {32'd0, b} / scale;
            return {1'b1, wide[31:0]};
        end
        if (cat == CATEGORY_MOVE && op == OPERATOR_MFHI) return {1'b1, model_hi};
        if (cat == CATEGORY_MOVE && op == OPERATOR_MFLO) return {1'b1, model_lo};
        return 33'd0;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] cat, input logic [31:0] a,
                                 input logic [31:0] b, input logic we, input logic [4:0] addr);
        logic [32:0] expected;
        logic [63:0] product;
        int cycles;
        operator               = op;
        category               = cat;
        operand_a              = a;
        operand_b              = b;
        register_write_enable  = we;
        register_write_address = addr;
        if (op == OPERATOR_MULTU) begin
            product = {32'd0, a} * {32'd0, b};
            cycles  = 0;
            @(negedge clock);
            while (stall_request === 1'b1 && cycles < 100) begin
                cycles++;
                checkOutput("multu_ex_en", {63'd0, ex_register_write_enable}, 64'd0);
                @(negedge clock);
                if (stall_request === 1'b1) checkOutput("bubble_mem_en", {63'd0, mem_register_write_enable}, 64'd0);
            end
            model_hi = product[63:32];
            model_lo = product[31:0];
            checkOutput("multu_stall_cycles", 64'(cycles), 64'd33);
            checkOutput("multu_hilo", {hi, lo}, product);
            checkOutput("done_ex_en", {63'd0, ex_register_write_enable}, 64'd0);
            @(posedge clock);
            #1;
            checkOutput("multu_mem_en", {63'd0, mem_register_write_enable}, 64'd0);
        end else begin
            expected = model_result(op, cat, a, b);
            @(negedge clock);
            checkOutput("stall", {63'd0, stall_request}, 64'd0);
            checkOutput("ex_en", {63'd0, ex_register_write_enable}, {63'd0, we & expected[32]});
            checkOutput("ex_data", {32'd0, ex_register_write_data}, {32'd0, expected[31:0]});
            checkOutput("ex_addr", {59'd0, ex_register_write_address}, {59'd0, addr});
            @(posedge clock);
            #1;
            checkOutput("mem_en", {63'd0, mem_register_write_enable}, {63'd0, we & expected[32]});
            checkOutput("mem_data", {32'd0, mem_register_write_data}, {32'd0, expected[31:0]});
            checkOutput("mem_addr", {59'd0, mem_register_write_address}, {59'd0, addr});
        end
    endtask

    logic [7:0] logic_ops [4];
    logic [7:0] shift_ops [3];

    initial begin
        checks   = 0;
        failures = 0;
        model_hi = '0;
        model_lo = '0;
        logic_ops = '{OPERATOR_AND, OPERATOR_OR, OPERATOR_XOR, OPERATOR_NOR};
        shift_ops = '{OPERATOR_SLL, OPERATOR_SRL, OPERATOR_SRA};

        reset                  = 1'b0;
        operator               = OPERATOR_NOP;
        category               = CATEGORY_NOP;
        operand_a              = '0;
        operand_b              = '0;
        register_write_enable  = 1'b0;
        register_write_address = '0;
        repeat (2) @(posedge clock);
        #1;
        operator = OPERATOR_MULTU;
        @(negedge clock);
        checkOutput("reset_stall_gated", {63'd0, stall_request}, 64'd0);
        checkOutput("reset_mem_en", {63'd0, mem_register_write_enable}, 64'd0);
        checkOutput("reset_mem_data", {32'd0, mem_register_write_data}, 64'd0);
        checkOutput("reset_hilo", {hi, lo}, 64'd0);
        @(posedge clock);
        #1;
        operator = OPERATOR_NOP;
        reset    = 1'b1;
        @(posedge clock);
        #1;

        applyStimulus(OPERATOR_OR, CATEGORY_LOGIC, 32'h0000_1234, 32'hFFFF_0000, 1'b1, 5'd5);
        applyStimulus(OPERATOR_SRA, CATEGORY_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd7);
        applyStimulus(OPERATOR_SRL, CATEGORY_SHIFT, 32'd4, 32'h8000_0000, 1'b1, 5'd8);
        applyStimulus(OPERATOR_NOR, CATEGORY_LOGIC, 32'd0, 32'd0, 1'b1, 5'd3);
        applyStimulus(OPERATOR_MULTU, CATEGORY_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0);
        applyStimulus(OPERATOR_MFLO, CATEGORY_MOVE, 32'd0, 32'd0, 1'b1, 5'd2);
        applyStimulus(OPERATOR_MFHI, CATEGORY_MOVE, 32'd0, 32'd0, 1'b1, 5'd4);
        applyStimulus(OPERATOR_MULTU, CATEGORY_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5'd0);
        applyStimulus(OPERATOR_MULTU, CATEGORY_MULT, 32'd3, 32'd5, 1'b0, 5'd0);
        applyStimulus(OPERATOR_MFLO, CATEGORY_MOVE, 32'd0, 32'd0, 1'b1, 5'd9);
        applyStimulus(OPERATOR_NOP, CATEGORY_NOP, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5'd11);
        applyStimulus(8'hFF, CATEGORY_LOGIC, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5'd12);
        applyStimulus(8'hAB, CATEGORY_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd13);

        // Abort a multiply mid-flight: cycle 11 after issue is BUSY with count 10.
        applyStimulus(OPERATOR_MULTU, CATEGORY_MULT, 32'h0000_0100, 32'h0000_0100, 1'b0, 5'd0);
        operand_a = 32'h7777_7777;
        operand_b = 32'h8888_8888;
        operator  = OPERATOR_MULTU;
        repeat (11) @(posedge clock);
        #1;
        checkOutput("busy_before_abort", {63'd0, stall_request}, 64'd1);
        reset    = 1'b0;
        operator = OPERATOR_NOP;
        category = CATEGORY_NOP;
        @(negedge clock);
        checkOutput("abort_stall_in_reset", {63'd0, stall_request}, 64'd0);
        @(posedge clock);
        #1;
        reset    = 1'b1;
        model_hi = '0;
        model_lo = '0;
        checkOutput("abort_stall", {63'd0, stall_request}, 64'd0);
        checkOutput("abort_hilo", {hi, lo}, 64'd0);
        checkOutput("abort_mem_en", {63'd0, mem_register_write_enable}, 64'd0);
        checkOutput("abort_mem_addr", {59'd0, mem_register_write_address}, 64'd0);
        checkOutput("abort_mem_data", {32'd0, mem_register_write_data}, 64'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 80; i++) begin
            int kind;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [4:0]  raddr;
            logic        rwe;
            kind  = $urandom_range(0, 20);
            ra    = $urandom;
            rb    = $urandom;
            raddr = 5'($urandom_range(0, 31));
            rwe   = 1'($urandom_range(0, 1));
            if (kind <= 6)
                applyStimulus(logic_ops[$urandom_range(0, 3)], CATEGORY_LOGIC, ra, rb, rwe, raddr);
            else if (kind <= 13)
                applyStimulus(shift_ops[$urandom_range(0, 2)], CATEGORY_SHIFT, ra, rb, rwe, raddr);
            else if (kind <= 16)
                applyStimulus(kind[0] ? OPERATOR_MFHI : OPERATOR_MFLO, CATEGORY_MOVE, ra, rb, rwe, raddr);
            else if (kind <= 18)
                applyStimulus(8'($urandom_range(8'hF0, 8'hFF)), 3'($urandom_range(0, 4)), ra, rb, rwe, raddr);
            else
                applyStimulus(OPERATOR_MULTU, CATEGORY_MULT, ra, rb, 1'b0, 5'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
